// File: rtl/shared_divider_pkg.sv
// Shared definitions for the shared divider and the average-speed stage that feeds it.
package shared_divider_pkg;
  localparam int DIV_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/shared_divider.sv
// Iterative restoring divider shared by two clients; one quotient bit per cycle, MSB first.
module shared_divider
  import shared_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             select,
  input  logic [WIDTH-1:0] dividend_a,
  input  logic [WIDTH-1:0] divisor_a,
  input  logic [WIDTH-1:0] dividend_b,
  input  logic [WIDTH-1:0] divisor_b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             owner
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] rem_nxt;
  logic             ge;
  logic             last;

  assign part    = {rem, dvd[WIDTH-1]};
  assign ge      = part >= {1'b0, dvs};
  // part never exceeds WIDTH bits after the restore, so truncation is lossless
  assign rem_nxt = ge ? WIDTH'(part - {1'b0, dvs}) : part[WIDTH-1:0];
  assign last    = (cnt == CNT_W'(1));

  assign busy  = (state == CALC);
  assign ready = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      owner       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          owner <= select;
          dvd   <= select ? dividend_b : dividend_a;
          dvs   <= select ? divisor_b  : divisor_a;
          rem   <= '0;
          cnt   <= CNT_W'(WIDTH);
        end
        CALC: begin
          dvd <= {dvd[WIDTH-2:0], ge};
          rem <= rem_nxt;
          cnt <= cnt - 1'b1;
          if (last) begin
            quotient    <= {dvd[WIDTH-2:0], ge};
            remainder   <= rem_nxt;
            div_by_zero <= (dvs == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_divider.sv
// Directed plus randomized checks of shared_divider against an arithmetic reference.
module tb_shared_divider;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         sel = 1'b0;
  logic [W-1:0] dda = '0, dsa = '0, ddb = '0, dsb = '0;
  logic         busy, ready, dbz, owner;
  logic [W-1:0] quotient, remainder;

  int n_chk  = 0;
  int n_fail = 0;

  shared_divider #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .select(sel),
    .dividend_a(dda), .divisor_a(dsa), .dividend_b(ddb), .divisor_b(dsb),
    .busy(busy), .ready(ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(dbz), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full operation: drive, count busy cycles until ready, compare against plain / and %.
  task automatic do_op(input string tag, input logic s, input logic [W-1:0] dd,
                       input logic [W-1:0] ds, input bit hold, input bit nosync);
    logic [W-1:0] eq, er;
    logic         edz;
    int           bc, it;
    if (ds == 0) begin eq = '1; er = dd; edz = 1'b1; end
    else begin eq = dd / ds; er = dd % ds; edz = 1'b0; end
    if (!nosync) @(negedge clk);
    sel = s;
    dda = W'($urandom); dsa = W'($urandom); ddb = W'($urandom); dsb = W'($urandom);
    if (s) begin ddb = dd; dsb = ds; end
    else   begin dda = dd; dsa = ds; end
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    bc = 0; it = 0;
    while (!ready && it < 40) begin
      if (busy) bc++;
      it++;
      if (hold) begin
        sel = 1'($urandom);
        dda = W'($urandom); dsa = W'($urandom); ddb = W'($urandom); dsb = W'($urandom);
      end
      @(posedge clk); #1;
    end
    check({tag, ".busy_cycles"}, bc, W);
    check({tag, ".ready_busy"}, {busy, ready}, 2'b01);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".dbz"}, dbz, edz);
    check({tag, ".owner"}, owner, s);
    @(posedge clk); #1;
    check({tag, ".after_done"}, {busy, ready}, 2'b00);
  endtask

  initial begin
    bit seen;
    logic [W-1:0] rd, rs;

    #3;
    check("reset.busy_ready", {busy, ready}, 2'b00);
    check("reset.results", {quotient, remainder, dbz, owner}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    do_op("b_36000_1800", 1'b1, 16'd36000, 16'd1800, 1'b0, 1'b0);
    do_op("a_65535_7",    1'b0, 16'd65535, 16'd7,    1'b0, 1'b0);
    do_op("a_div0",       1'b0, 16'd1234,  16'd0,    1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("hold.results", {quotient, remainder, dbz}, {16'd65535, 16'd1234, 1'b1});

    // start held high and operands scrambled mid-flight; the following op is
    // issued straight after the ignored start in the DONE cycle
    do_op("held_start",   1'b0, 16'd50000, 16'd123, 1'b1, 1'b0);
    do_op("back_to_back", 1'b1, 16'd40000, 16'd7,   1'b0, 1'b0);

    @(negedge clk);
    sel = 1'b0; dda = 16'd60000; dsa = 16'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midreset.busy_ready", {busy, ready}, 2'b00);
    check("midreset.results", {quotient, remainder, dbz, owner}, '0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (busy || ready) seen = 1'b1;
    end
    check("midreset.quiet", seen, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    do_op("post_reset_100_3", 1'b0, 16'd100, 16'd3, 1'b0, 1'b1);

    do_op("dividend0",   1'b1, 16'd0,   16'd77,  1'b0, 1'b0);
    do_op("dvs_gt_dvd",  1'b0, 16'd500, 16'd501, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rd = W'($urandom);
      if ($urandom_range(0, 5) == 0) rd = '0;
      case ($urandom_range(0, 3))
        0:       rs = '0;
        1:       rs = W'($urandom_range(1, 15));
        2:       rs = W'($urandom_range(1, 255));
        default: rs = W'($urandom);
      endcase
      do_op($sformatf("rand%0d", i), 1'($urandom), rd, rs, bit'($urandom_range(0, 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
